// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Imported by div_unit and div_restoring_step.
package div_pkg;

    localparam int DIV_OP_WIDTH = 2;

    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'd0;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'd1;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'd2;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        DONE,
        DRAIN
    } div_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring shift-subtract iteration: produces one quotient bit
// shifted into the low end of the dividend register.
module div_restoring_step
    import div_pkg::*;
(
    input  logic [31:0] rem,
    input  logic [31:0] dvd,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] dvd_next
);

    logic [31:0] rem_sh;
    logic [32:0] trial;
    logic        q_bit;

    // Shift in the next dividend bit and try subtracting the divisor.
    always_comb begin
        rem_sh   = {rem[30:0], dvd[31]};
        trial    = {1'b0, rem_sh} - {1'b0, divisor};
        q_bit    = ~trial[32];
        rem_next = q_bit ? trial[31:0] : rem_sh;
        dvd_next = {dvd[30:0], q_bit};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider for DIV/DIVU/REM/REMU with a
// valid/ready handshake and a fast path for special cases.
module div_unit
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    div_valid,
    input  logic [DIV_OP_WIDTH-1:0] DIVop,
    input  logic [31:0]             dividend,
    input  logic [31:0]             divisor,
    output logic [31:0]             div_result,
    output logic                    div_ready
);

    div_state_t  state_q, state_d;
    logic        rem_op_q, rem_op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic        signed_op;
    logic        is_rem;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] step_rem;
    logic [31:0] step_dvd;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Decode the incoming request and form absolute operand values.
    always_comb begin
        signed_op = (DIVop == DIV_OP_DIV) || (DIVop == DIV_OP_REM);
        is_rem    = (DIVop == DIV_OP_REM) || (DIVop == DIV_OP_REMU);
        a_neg     = signed_op & dividend[31];
        b_neg     = signed_op & divisor[31];
        abs_a     = a_neg ? (~dividend + 32'd1) : dividend;
        abs_b     = b_neg ? (~divisor + 32'd1) : divisor;
    end

    div_restoring_step u_step (
        .rem      (rem_q),
        .dvd      (dvd_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .dvd_next (step_dvd)
    );

    // Restore result signs from the latched operand signs.
    always_comb begin
        quo_fix = (sign_a_q ^ sign_b_q) ? (~dvd_q + 32'd1) : dvd_q;
        rem_fix = sign_a_q ? (~rem_q + 32'd1) : rem_q;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        rem_op_d = rem_op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (div_valid) begin
                    rem_op_d = is_rem;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    dvd_d    = abs_a;
                    dvs_d    = abs_b;
                    rem_d    = 32'd0;
                    cnt_d    = 5'd0;
                    if (divisor == 32'd0) begin
                        result_d = is_rem ? dividend : 32'hFFFF_FFFF;
                        state_d  = DONE;
                    end else if (signed_op &&
                                 dividend == 32'h8000_0000 &&
                                 divisor == 32'hFFFF_FFFF) begin
                        result_d = is_rem ? 32'd0 : 32'h8000_0000;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = rem_op_q ? rem_fix : quo_fix;
                state_d  = DONE;
            end
            DONE: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!div_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_op_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dvd_q    <= 32'd0;
            dvs_q    <= 32'd0;
            rem_q    <= 32'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            rem_op_q <= rem_op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign div_ready  = (state_q == DONE);
    assign div_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit with an
// arithmetic reference model and a per-cycle result monitor.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_valid;
    logic [1:0]  DIVop;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] div_result;
    logic        div_ready;

    int          tests;
    int          fails;
    logic [31:0] exp_q[$];
    logic        prev_ready;

    div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .DIVop      (DIVop),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_result (div_result),
        .div_ready  (div_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int  sa;
        int  sb;
        logic want_rem;
        want_rem = (op == 2'd2) || (op == 2'd3);
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0)
            return want_rem ? a : 32'hFFFF_FFFF;
        if (op == 2'd0 || op == 2'd2) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return want_rem ? 32'd0 : 32'h8000_0000;
            return want_rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return want_rem ? (a % b) : (a / b);
    endfunction

    function automatic int latency(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 1;
        if ((op == 2'd0 || op == 2'd2) &&
            a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Result monitor: every ready pulse must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (div_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ready result=%h", div_result);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (div_result !== e) begin
                    fails++;
                    $display("FAIL result got=%h exp=%h", div_result, e);
                end
            end
            tests++;
            if (prev_ready) begin
                fails++;
                $display("FAIL ready_width got=2+ cycles exp=1");
            end
        end
        prev_ready = div_ready;
    end

    task automatic do_op(input logic [1:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int hold,
                         input logic has_lit,
                         input logic [31:0] lit);
        int   n;
        logic got;
        int   exp_lat;
        logic [31:0] m;
        m = model(op, a, b);
        if (has_lit) begin
            tests++;
            if (m !== lit) begin
                fails++;
                $display("FAIL model_pin op=%0d a=%h b=%h got=%h exp=%h",
                         op, a, b, m, lit);
            end
        end
        exp_lat = latency(op, a, b);
        @(negedge clk);
        DIVop     = op;
        dividend  = a;
        divisor   = b;
        div_valid = 1'b1;
        exp_q.push_back(m);
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (div_ready) got = 1'b1;
            else if (n == 1) begin
                DIVop    = 2'($urandom_range(0, 3));
                dividend = $urandom;
                divisor  = $urandom;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL timeout op=%0d a=%h b=%h cycles=%0d", op, a, b, n);
            exp_q.delete();
        end else if (n != exp_lat) begin
            fails++;
            $display("FAIL latency op=%0d got=%0d exp=%0d", op, n, exp_lat);
        end
        repeat (hold) @(negedge clk);
        @(negedge clk);
        div_valid = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) @(negedge clk);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        prev_ready = 1'b0;
        reset      = 1'b1;
        div_valid  = 1'b0;
        DIVop      = 2'd0;
        dividend   = 32'd0;
        divisor    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (div_ready !== 1'b0 || div_result !== 32'd0) begin
            fails++;
            $display("FAIL reset_state ready=%b result=%h exp 0/0",
                     div_ready, div_result);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        do_op(2'd1, 32'd100, 32'd7, 0, 1'b1, 32'h0000_000E);
        idle(2);
        do_op(2'd3, 32'd100, 32'd7, 0, 1'b1, 32'h0000_0002);
        idle(2);
        do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFD);
        idle(2);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFF);
        idle(2);
        do_op(2'd0, 32'd7, 32'hFFFF_FFFE, 0, 1'b1, 32'hFFFF_FFFD);
        idle(2);
        do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 0, 1'b1, 32'h0000_0001);
        idle(2);
        do_op(2'd1, 32'd5, 32'd0, 0, 1'b1, 32'hFFFF_FFFF);
        idle(2);
        do_op(2'd3, 32'd5, 32'd0, 0, 1'b1, 32'h0000_0005);
        idle(2);
        do_op(2'd0, 32'hFFFF_FFF9, 32'd0, 0, 1'b1, 32'hFFFF_FFFF);
        idle(2);
        do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h8000_0000);
        idle(2);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0000);
        idle(2);

        // Reset in the middle of a calculation.
        @(negedge clk);
        DIVop     = 2'd1;
        dividend  = 32'd1234567;
        divisor   = 32'd3;
        div_valid = 1'b1;
        repeat (11) @(negedge clk);
        reset     = 1'b1;
        div_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (div_ready !== 1'b0 || div_result !== 32'd0) begin
            fails++;
            $display("FAIL mid_reset ready=%b result=%h exp 0/0",
                     div_ready, div_result);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(40);
        do_op(2'd1, 32'hFFFF_FFFF, 32'd1, 0, 1'b1, 32'hFFFF_FFFF);
        idle(2);

        // Valid held past ready, then a fresh request after one low cycle.
        do_op(2'd1, 32'd1000, 32'd9, 3, 1'b1, 32'd111);
        do_op(2'd1, 32'd9, 32'd3, 0, 1'b1, 32'h0000_0003);
        idle(40);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom >> 16;
                default: b = $urandom;
            endcase
            do_op(op, a, b, $urandom_range(0, 2), 1'b0, 32'd0);
            idle(1);
        end
        idle(40);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_results got=%0d exp=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
